// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path definitions: default FIFO depth and capture FSM encoding.
package uart_rx_fifo_pkg;

  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_ACK  = 2'd1,
    CAP_WAIT = 2'd2
  } cap_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for asynchronous status lines; clears to 0 on reset.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the CPU bus; captures each flagged byte once.
// Define UART_RXFIFO_FWFT_EN for first-word fall-through reads (default: registered read).
//
// state    | meaning
// CAP_IDLE | waiting for synchronised byte-available status
// CAP_ACK  | byte written (or dropped); pulsing rx_over_read
// CAP_WAIT | waiting for the receiver status to fall
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_rs,
  output logic          rx_over_read,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  input  logic          ovr_clr
);

  localparam logic [AW:0]   COUNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   COUNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE    = 1;

  cap_state_t      state, state_nxt;
  logic            rs_s;
  logic            capture;
  logic            push;
  logic            pop;
  logic            ovr_set;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count_q;
  logic [7:0]      mem [DEPTH];

  uart_sync2 u_sync_rs (
    .clk (clk),
    .rst (rst),
    .d   (rx_rs),
    .q   (rs_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CAP_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = CAP_IDLE;
    rx_over_read = 1'b0;
    capture      = 1'b0;
    case (state)
      CAP_IDLE: begin
        if (rs_s) begin
          capture   = 1'b1;
          state_nxt = CAP_ACK;
        end
      end
      CAP_ACK: begin
        rx_over_read = 1'b1;
        state_nxt    = CAP_WAIT;
      end
      CAP_WAIT: state_nxt = rs_s ? CAP_WAIT : CAP_IDLE;
      default:  state_nxt = CAP_IDLE;
    endcase
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == COUNT_FULL);
  assign count   = count_q;
  assign pop     = rd_en && !empty;
  // A pop on the same edge frees the head slot, so a capture while full still fits.
  assign push    = capture && (!full || pop);
  assign ovr_set = capture && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count_q <= count_q + COUNT_ONE;
      else if (pop && !push) count_q <= count_q - COUNT_ONE;
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

`ifdef UART_RXFIFO_FWFT_EN
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      rd_data <= 8'h00;
    else if (pop) rd_data <= mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: bytes pushed into an expected queue, compared on pop.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_rs;
  logic       rx_over_read;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overrun;
  logic       ovr_clr;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(8), .AW(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_rs        (rx_rs),
    .rx_over_read (rx_over_read),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overrun      (overrun),
    .ovr_clr      (ovr_clr)
  );

  // Raise status, hold it, drop it and let the capture FSM return to idle.
  task automatic send_byte(input logic [7:0] b, output int pulses);
    @(negedge clk);
    rx_data = b;
    rx_rs   = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rx_over_read) pulses++;
    end
    rx_rs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rx_over_read) pulses++;
    end
    if (exp_q.size() < 8) exp_q.push_back(b);
  endtask

  task automatic pop_byte(output logic [7:0] got);
    @(negedge clk);
`ifdef UART_RXFIFO_FWFT_EN
    got = rd_data;
`endif
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
`ifndef UART_RXFIFO_FWFT_EN
    got = rd_data;
`endif
  endtask

  function automatic logic [7:0] next_exp();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    rst = 1'b1; rx_data = 8'h00; rx_rs = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({rx_over_read, rd_data, empty, full, count, overrun} !== {1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0}) begin
      $display("FAIL reset: ovr_rd=%b rd_data=%h empty=%b full=%b count=%0d overrun=%b",
               rx_over_read, rd_data, empty, full, count, overrun);
      n_fail++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_one_byte();
    logic [3:0] seen;
    logic [3:0] cnt_e2;
    logic       empty_e2;
    logic [7:0] got, exp;
    @(negedge clk);
    rx_data = 8'hA5;
    rx_rs   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen[k] = rx_over_read;
      if (k == 2) begin
        cnt_e2   = count;
        empty_e2 = empty;
      end
    end
    rx_rs = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'hA5);
    n_tests++;
    if (seen !== 4'b0100) begin
      $display("FAIL one_byte_pulse: pulse samples E..E+3 got %b want 0100", seen);
      n_fail++;
    end
    n_tests++;
    if ({cnt_e2, empty_e2} !== {4'd1, 1'b0}) begin
      $display("FAIL one_byte_count: count=%0d empty=%b want count=1 empty=0", cnt_e2, empty_e2);
      n_fail++;
    end
    pop_byte(got);
    exp = next_exp();
    n_tests++;
    if (got !== exp) begin
      $display("FAIL one_byte_data: got %h want %h", got, exp);
      n_fail++;
    end
  endtask

  task automatic test_fill_overflow();
    int p, bad;
    logic [7:0] got, exp;
    bad = 0;
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i), p);
      if (p != 1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      $display("FAIL fill_ack: %0d bytes without exactly one pulse, want 0", bad);
      n_fail++;
    end
    n_tests++;
    if ({full, count, overrun} !== {1'b1, 4'd8, 1'b1}) begin
      $display("FAIL fill_flags: full=%b count=%0d overrun=%b want 1/8/1", full, count, overrun);
      n_fail++;
    end
    for (int i = 0; i < 8; i++) begin
      pop_byte(got);
      exp = next_exp();
      n_tests++;
      if (got !== exp) begin
        $display("FAIL fill_order[%0d]: got %h want %h", i, got, exp);
        n_fail++;
      end
    end
    n_tests++;
    if ({empty, count} !== {1'b1, 4'd0}) begin
      $display("FAIL fill_drain: empty=%b count=%0d want 1/0", empty, count);
      n_fail++;
    end
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    n_tests++;
    if (overrun !== 1'b0) begin
      $display("FAIL ovr_clr: overrun=%b want 0", overrun);
      n_fail++;
    end
  endtask

  task automatic test_wrap();
    int p, errs, maxc;
    logic [7:0] got, exp;
    errs = 0; maxc = 0;
    for (int i = 0; i < 20; i++) begin
      send_byte(8'h80 + 8'(i), p);
      if (int'(count) > maxc) maxc = int'(count);
      pop_byte(got);
      exp = next_exp();
      if (got !== exp) begin
        errs++;
        $display("FAIL wrap_data[%0d]: got %h want %h", i, got, exp);
      end
    end
    n_tests++;
    if (errs != 0) n_fail++;
    n_tests++;
    if (maxc != 1) begin
      $display("FAIL wrap_count: max count %0d want 1", maxc);
      n_fail++;
    end
  endtask

  task automatic test_simul_full();
    int p;
    logic [7:0] got, exp, hold;
    for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i), p);
    @(negedge clk);
    rx_data = 8'h48;
    rx_rs   = 1'b1;
    @(negedge clk);
    @(negedge clk);
`ifdef UART_RXFIFO_FWFT_EN
    got = rd_data;
`endif
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
`ifndef UART_RXFIFO_FWFT_EN
    got = rd_data;
`endif
    exp = next_exp();
    exp_q.push_back(8'h48);
    n_tests++;
    if ({count, overrun, full} !== {4'd8, 1'b0, 1'b1}) begin
      $display("FAIL simul_full: count=%0d overrun=%b full=%b want 8/0/1", count, overrun, full);
      n_fail++;
    end
    n_tests++;
    if (got !== exp) begin
      $display("FAIL simul_pop: got %h want %h", got, exp);
      n_fail++;
    end
    rx_rs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      pop_byte(got);
      exp = next_exp();
      n_tests++;
      if (got !== exp) begin
        $display("FAIL simul_drain[%0d]: got %h want %h", i, got, exp);
        n_fail++;
      end
    end
    hold = rd_data;
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    n_tests++;
    if ({count, empty, rd_data} !== {4'd0, 1'b1, hold}) begin
      $display("FAIL rd_empty: count=%0d empty=%b rd_data=%h want 0/1/%h", count, empty, rd_data, hold);
      n_fail++;
    end
  endtask

  task automatic test_hold_high();
    int p;
    logic [7:0] got, exp;
    @(negedge clk);
    rx_data = 8'h77;
    rx_rs   = 1'b1;
    p = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rx_over_read) p++;
    end
    rx_rs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rx_over_read) p++;
    end
    exp_q.push_back(8'h77);
    n_tests++;
    if ({p[3:0], count} !== {4'd1, 4'd1}) begin
      $display("FAIL hold_high: pulses=%0d count=%0d want 1/1", p, count);
      n_fail++;
    end
    pop_byte(got);
    exp = next_exp();
    n_tests++;
    if (got !== exp) begin
      $display("FAIL hold_data: got %h want %h", got, exp);
      n_fail++;
    end
  endtask

  task automatic test_ovr_priority();
    int p;
    logic [7:0] got, exp;
    for (int i = 0; i < 8; i++) send_byte(8'h60 + 8'(i), p);
    @(negedge clk);
    rx_data = 8'h68;
    rx_rs   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    n_tests++;
    if (overrun !== 1'b1) begin
      $display("FAIL ovr_priority: overrun=%b want 1", overrun);
      n_fail++;
    end
    rx_rs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      pop_byte(got);
      exp = next_exp();
      n_tests++;
      if (got !== exp) begin
        $display("FAIL ovr_drain[%0d]: got %h want %h", i, got, exp);
        n_fail++;
      end
    end
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int p;
    bit found;
    logic [7:0] got, exp;
    send_byte(8'h31, p);
    send_byte(8'h32, p);
    @(negedge clk);
    rx_data = 8'h33;
    rx_rs   = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (rx_over_read) found = 1'b1;
    end
    @(negedge clk);
    n_tests++;
    if ({found, count} !== {1'b1, 4'd3}) begin
      $display("FAIL pre_reset: pulse_seen=%b count=%0d want 1/3", found, count);
      n_fail++;
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({rx_over_read, rd_data, empty, full, count, overrun} !== {1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0}) begin
      $display("FAIL mid_reset: ovr_rd=%b rd_data=%h empty=%b full=%b count=%0d overrun=%b",
               rx_over_read, rd_data, empty, full, count, overrun);
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h33);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (rx_over_read) found = 1'b1;
    end
    rx_rs = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if ({found, count} !== {1'b1, 4'd1}) begin
      $display("FAIL post_reset_capture: pulse_seen=%b count=%0d want 1/1", found, count);
      n_fail++;
    end
    pop_byte(got);
    exp = next_exp();
    n_tests++;
    if (got !== exp) begin
      $display("FAIL post_reset_data: got %h want %h", got, exp);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_fill_overflow();
    test_wrap();
    test_simul_full();
    test_hold_high();
    test_ovr_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer between the UART receiving unit and the CPU bus interface. It watches the receiver's byte-available status and copies each received byte into a small FIFO. It then pulses the receiver's clear input so the receiver can flag the next byte. The CPU drains bytes at its own pace, which absorbs bus latency that would otherwise lose characters.

## Interface
- DEPTH, 8: FIFO entries. Must be a power of 2, ≥2.
- AW, 3: pointer width, equal to log2(DEPTH).

- clk  in  1  system clock; the same clock as the receiving unit.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  8  received byte from the receiving unit's data output.
- rx_rs  in  1  receiver status (byte available) from the receiving unit. Treated as asynchronous.
- rx_over_read  out  1  one-cycle clear pulse to the receiving unit's over_read input.
- rd_en  in  1  CPU pop request.
- rd_data  out  8  head byte.
- empty  out  1  FIFO holds 0 entries.
- full  out  1  FIFO holds DEPTH entries.
- count  out  AW+1  number of stored entries, 0..DEPTH.
- overrun  out  1  sticky flag: a byte was dropped because the FIFO was full.
- ovr_clr  in  1  clears overrun.

## Operation
- rx_rs passes through a 2-flop synchroniser to give rs_s.
- Capture FSM, 2 bits:
  - CAP_IDLE: when rs_s=1, go to CAP_ACK.
    - If !full, write rx_data at wr_ptr on this edge.
    - If full, do not write and set overrun.
  - CAP_ACK: assert rx_over_read for exactly this one cycle, then go to CAP_WAIT.
  - CAP_WAIT: stay until rs_s=0, then go to CAP_IDLE. This guarantees exactly one capture per received byte.
  - Unused encoding: go to CAP_IDLE.
- Pointers wr_ptr and rd_ptr are AW bits wide and wrap modulo DEPTH with no special case.
- count is kept as a separate register:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop happen in the same cycle.
- Pop is effective when rd_en && !empty. rd_en while empty is ignored: no pointer or count change and no error.
- Push and pop in the same cycle:
  - When full: both proceed, count stays DEPTH, no overrun.
  - When empty: the push proceeds; the pop is ignored because empty is evaluated pre-edge.
- overrun priority: set beats ovr_clr in the same cycle.
- Reset mid-operation:
  - FSM goes to CAP_IDLE, pointers and count go to 0, synchroniser is cleared.
  - The stored contents are discarded.
  - A byte still flagged in the receiver is captured after reset, because rs_s rises again.

## Timing
- Reset values: rx_over_read=0, rd_data=0, empty=1, full=0, count=0, overrun=0.
- Latency from rx_rs rising (sampled at edge E) to the write and the CAP_ACK entry: edge E+2.
  - count, empty and full update after edge E+2.
  - rx_over_read is high from edge E+2 to edge E+3.
- The receiving unit's data output is stable from the status rising until the next frame's first data sample, far longer than 3 cycles, so the capture needs no extra holding register.
- empty, full and count are registered, or derived only from registered count.
- Minimum spacing between captures is 3 cycles plus the rs_s fall.

## Configuration
- UART_RXFIFO_FWFT_EN defined (first-word fall-through):
  - rd_data = mem[rd_ptr] combinationally.
  - Valid whenever !empty; rd_en acknowledges the head.
- Not defined (registered read):
  - rd_data is loaded from mem[rd_ptr] on the edge where rd_en && !empty.
  - It is valid the following cycle and holds its value otherwise, including after the FIFO empties.

## Structure
- Shared UART header/package holds:
  - the default DEPTH;
  - the capture FSM state constants CAP_IDLE=0, CAP_ACK=1, CAP_WAIT=2.
- One sub-module: uart_sync2, a generic 2-flop synchroniser with asynchronous reset, value 0 on reset. It is reusable for other asynchronous status lines.
- Storage is an inferred register array inside uart_rx_fifo.

## Test plan
- Reset, then one byte:
  - Stimulus: rx_data=0xA5, rx_rs raised.
  - Required: rx_over_read is a single pulse exactly 2 edges after rx_rs is sampled; count=1, empty=0.
  - With FWFT: rd_data=0xA5 immediately. Without FWFT: rd_data=0xA5 one cycle after rd_en.
- Fill and overflow:
  - Stimulus: push 9 bytes 0x01..0x09 with DEPTH=8, no pops.
  - Required: full=1, count=8, overrun=1, 0x09 dropped, the 9th byte still acknowledged.
  - Then pop 8 times: read 0x01..0x08 in order, empty=1.
- Pointer wrap:
  - Stimulus: 20 push/pop pairs of an incrementing pattern.
  - Required: data order preserved across the wrap, count never exceeds 1.
- Simultaneous push and pop at full:
  - Required: count stays 8, no overrun.
  - rd_en while empty: count stays 0, rd_data unchanged.
- rx_rs held high for 10 cycles:
  - Required: exactly one capture and one rx_over_read pulse.
  - ovr_clr together with a new overrun in the same cycle: overrun stays 1.
- rst asserted in CAP_WAIT with 3 entries stored:
  - Required: all outputs return to reset values immediately.
